aer_frame_scheduler: RTL

- Per-timestep sequencer for the synapse layer.
- Captures the input-layer spike vector on each timestep tick and serialises it onto the AER bus, one address per cycle, lowest index first.
- Issues the frame-end word so the synapse accumulators present and then clear their sums.
- Optionally replays the same addresses with the learning strobe T high, so the BCM weight blocks update against layer-2 post spikes.

---
 rtl/aer_frame_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/aer_frame_scheduler.sv
// Per-timestep AER sequencer: captures a spike vector on tick, serialises it lowest index first,
// issues the frame-end word and optionally replays the addresses with the learning strobe T.
module aer_frame_scheduler #(
  parameter int In_neurons = 5,
  parameter int AW         = $clog2(In_neurons)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [In_neurons-1:0] spikes_in,
  input  logic                  learn_en,
  input  logic                  post_done,
  output logic [AW:0]           AER_BUS,
  output logic                  T,
  output logic                  sum_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  // state     | meaning
  // IDLE      | frame-end word held, accumulators kept at zero, waiting for tick
  // SCAN      | one spike address per cycle, lowest index first
  // FLUSH     | frame-end word with sum_valid, synapse sums presented
  // WAIT_POST | frame-end word held until layer-2 post spikes are stable
  // LEARN     | saved addresses replayed with T high
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SCAN      = 3'd1,
    FLUSH     = 3'd2,
    WAIT_POST = 3'd3,
    LEARN     = 3'd4
  } state_t;

  localparam logic [AW:0] FRAME_END = {1'b1, {AW{1'b0}}};

  state_t                state_q, state_d;
  logic [In_neurons-1:0] pend_q, pend_d;
  logic [In_neurons-1:0] save_q, save_d;
  logic                  learn_q, learn_d;
  logic [AW:0]           aer_q, aer_d;
  logic                  sum_valid_q, sum_valid_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overrun_q, overrun_d;
  logic                  t_q, t_d;

  function automatic logic [AW-1:0] low_idx(input logic [In_neurons-1:0] v);
    logic [AW-1:0] idx;
    idx = '0;
    for (int i = In_neurons - 1; i >= 0; i--) begin
      if (v[i]) idx = AW'(i);
    end
    return idx;
  endfunction

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    save_d    = save_q;
    learn_d   = learn_q;
    overrun_d = overrun_q | (tick & (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (tick) begin
          pend_d  = spikes_in;
          save_d  = spikes_in;
          learn_d = learn_en;
          state_d = (spikes_in != '0) ? SCAN : FLUSH;
        end
      end
      SCAN: begin
        // x & (x-1) drops the lowest set bit, i.e. the address shown this cycle
        pend_d = pend_q & (pend_q - In_neurons'(1));
        if (pend_d == '0) state_d = FLUSH;
      end
      FLUSH: begin
        state_d = (learn_q && (save_q != '0)) ? WAIT_POST : IDLE;
      end
      WAIT_POST: begin
        if (post_done) begin
          pend_d  = save_q;
          state_d = LEARN;
        end
      end
      LEARN: begin
        pend_d = pend_q & (pend_q - In_neurons'(1));
        if (pend_d == '0) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next-state view so they line up with the state itself.
    aer_d = FRAME_END;
    if ((state_d == SCAN) || (state_d == LEARN)) aer_d = {1'b0, low_idx(pend_d)};
    sum_valid_d  = (state_d == FLUSH);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_q != IDLE) && (state_d == IDLE);
    t_d          = (state_d == LEARN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      save_q       <= '0;
      learn_q      <= 1'b0;
      aer_q        <= FRAME_END;
      sum_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      save_q       <= save_d;
      learn_q      <= learn_d;
      aer_q        <= aer_d;
      sum_valid_q  <= sum_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // T only moves while clk is low so clk & T is a clean gated clock for the BCM blocks.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) t_q <= 1'b0;
    else        t_q <= t_d;
  end

  assign AER_BUS    = aer_q;
  assign T          = t_q;
  assign sum_valid  = sum_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule
